// File: rtl/pipeline_pkg.sv
// Shared constants and helpers for the pipeline drain FIFO.
// Width helper keeps level sizing consistent across files.
package pipeline_pkg;

    localparam int XLEN_DEFAULT         = 32;
    localparam int DEPTH_DEFAULT        = 8;
    localparam int AFULL_MARGIN_DEFAULT = 2;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef enum logic [1:0] {
        OCC_HOLD = 2'b00,
        OCC_POP  = 2'b01,
        OCC_PUSH = 2'b10,
        OCC_BOTH = 2'b11
    } occ_op_e;

endpackage

// File: rtl/pipeline_drain_fifo_if.sv
// Handshake bundle between the last pipeline stage, the FIFO
// and the downstream consumer.
interface pipeline_drain_fifo_if
    import pipeline_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
);

    logic                        in_valid;
    logic [XLEN-1:0]             in_data;
    logic                        stall_req;
    logic                        out_valid;
    logic                        out_ready;
    logic [XLEN-1:0]             out_data;
    logic [level_w(DEPTH)-1:0]   level;
    logic                        overflow;

    modport master (
        output in_valid, in_data, out_ready,
        input  stall_req, out_valid, out_data, level, overflow
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output stall_req, out_valid, out_data, level, overflow
    );

endinterface

// File: rtl/pipeline_fifo_mem.sv
// Storage array: one write port, asynchronous read, no reset.
module pipeline_fifo_mem #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [XLEN-1:0]          rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipeline_drain_fifo.sv
// First-word-fall-through FIFO absorbing the tail of a pipeline,
// with a registered early stall request and a sticky overflow flag.
module pipeline_drain_fifo
    import pipeline_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int DEPTH        = DEPTH_DEFAULT,
    parameter int AFULL_MARGIN = AFULL_MARGIN_DEFAULT
) (
    input logic                 clock,
    input logic                 reset,
    pipeline_drain_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    typedef logic [LW-1:0] level_t;

    localparam level_t FULL     = level_t'(DEPTH);
    localparam level_t STALL_AT = level_t'(DEPTH - AFULL_MARGIN);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 4");
    end
    if (AFULL_MARGIN < 1 || AFULL_MARGIN > DEPTH - 1) begin : g_bad_margin
        $error("AFULL_MARGIN must be in 1..DEPTH-1");
    end

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    level_t          level_q;
    level_t          level_nxt;
    logic            stall_q;
    logic            ovf_q;
    logic            out_valid;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] rd_data;
    occ_op_e         op;

    assign out_valid = (level_q != '0);
    assign pop       = out_valid & bus.out_ready;
    assign push      = bus.in_valid & ((level_q < FULL) | pop);
    assign op        = occ_op_e'({push, pop});

    always_comb begin
        level_nxt = level_q;
        unique case (op)
            OCC_PUSH: level_nxt = level_q + 1'b1;
            OCC_POP:  level_nxt = level_q - 1'b1;
            default:  level_nxt = level_q;
        endcase
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level_q <= level_nxt;
            stall_q <= (level_nxt >= STALL_AT);
            if (bus.in_valid && !push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    pipeline_fifo_mem #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock (clock),
        .we    (push & ~reset),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_valid ? rd_data : '0;
    assign bus.level     = level_q;
    assign bus.stall_req = stall_q;
    assign bus.overflow  = ovf_q;

endmodule
